// File: rtl/tft_pkg.sv
// ---------------------------------------------------------------------------
// tft_pkg
//   Shared definitions for the TFT command sequencer:
//     - init ROM word kinds ({kind[1:0], payload[7:0]})
//     - panel window opcodes (CASET / PASET / RAMWR)
//     - sequencer state and "who issued this byte" encodings
//     - winWord(): the 11-word window setup sequence as a lookup
// ---------------------------------------------------------------------------
package tft_pkg;

    // Init ROM word kinds
    localparam logic [1:0] KIND_CMD   = 2'b00;
    localparam logic [1:0] KIND_DATA  = 2'b01;
    localparam logic [1:0] KIND_DELAY = 2'b10;
    localparam logic [1:0] KIND_END   = 2'b11;

    // Panel opcodes used for the per-frame window setup
    localparam logic [7:0] OP_CASET = 8'h2A;
    localparam logic [7:0] OP_PASET = 8'h2B;
    localparam logic [7:0] OP_RAMWR = 8'h2C;

    // Number of words in the window setup sequence
    localparam int WIN_WORDS = 11;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_ISSUE,
        ST_ACK,
        ST_WAIT,
        ST_DELAY,
        ST_WIN,
        ST_PIX_HI,
        ST_PIX_LO
    } state_t;

    // Remembers which phase produced the byte currently in the handshake,
    // so WAIT knows where to continue once the serializer is idle again.
    typedef enum logic [1:0] {
        SRC_INIT,
        SRC_WIN,
        SRC_PIX_HI,
        SRC_PIX_LO
    } src_t;

    // Window setup word idx (0..10) as {dc, byte}. Opcodes go out with dc=0,
    // the column/row start (always 0) and end coordinates with dc=1.
    function automatic logic [8:0] winWord(input logic [3:0]  idx,
                                           input logic [15:0] colEnd,
                                           input logic [15:0] rowEnd);
        logic [8:0] w;
        case (idx)
            4'd0:    w = {1'b0, OP_CASET};
            4'd1:    w = {1'b1, 8'h00};
            4'd2:    w = {1'b1, 8'h00};
            4'd3:    w = {1'b1, colEnd[15:8]};
            4'd4:    w = {1'b1, colEnd[7:0]};
            4'd5:    w = {1'b0, OP_PASET};
            4'd6:    w = {1'b1, 8'h00};
            4'd7:    w = {1'b1, 8'h00};
            4'd8:    w = {1'b1, rowEnd[15:8]};
            4'd9:    w = {1'b1, rowEnd[7:0]};
            default: w = {1'b0, OP_RAMWR};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/tft_init_rom.sv
// ---------------------------------------------------------------------------
// tft_init_rom
//   Combinational panel init script. Each entry is {kind[1:0], payload[7:0]}:
//   CMD / DATA bytes for the serializer, DELAY in units of DELAY_UNIT clocks,
//   and an END marker. Every address past the script reads as END.
// Ports
//   i_addr  in   ROM_AW  script index
//   o_word  out  10      script entry at i_addr
// ---------------------------------------------------------------------------
module tft_init_rom
    import tft_pkg::*;
#(
    parameter int ROM_AW = 6
)(
    input  logic [ROM_AW-1:0] i_addr,
    output logic [9:0]        o_word
);

    // Software reset, sleep out, 16-bit colour, memory access control,
    // display on. Delays give the controller time to settle after reset
    // and sleep-out.
    always_comb begin
        o_word = {KIND_END, 8'h00};
        case (int'(i_addr))
            0:       o_word = {KIND_CMD,   8'h01};
            1:       o_word = {KIND_DELAY, 8'h05};
            2:       o_word = {KIND_CMD,   8'h11};
            3:       o_word = {KIND_DELAY, 8'h0C};
            4:       o_word = {KIND_CMD,   8'h3A};
            5:       o_word = {KIND_DATA,  8'h55};
            6:       o_word = {KIND_CMD,   8'h36};
            7:       o_word = {KIND_DATA,  8'h48};
            8:       o_word = {KIND_CMD,   8'h29};
            9:       o_word = {KIND_DELAY, 8'h01};
            default: o_word = {KIND_END,   8'h00};
        endcase
    end

endmodule

// File: rtl/tft_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tft_cmd_sequencer
//   Feeds {dc, byte} words to a 9-bit TFT SPI serializer. After reset it
//   plays the init ROM script (commands, data, timed delays), then loops
//   forever: window setup (CASET/PASET/RAMWR) followed by one frame of
//   RGB565 pixels sent as high/low byte pairs.
// Ports
//   spiClk             in   1   clock, everything on the rising edge
//   reset              in   1   asynchronous, active-high
//   spi_idle           in   1   serializer ready for a new word
//   spi_data           out  9   {dc, byte}; dc=0 command, dc=1 data
//   spi_dataAvailable  out  1   one-cycle load strobe to the serializer
//   pix_data           in   16  RGB565 pixel
//   pix_valid          in   1   pixel source has a pixel
//   pix_ready          out  1   one-cycle pixel accept strobe
//   init_done          out  1   init script finished (sticky until reset)
//   frame_start        out  1   pulses with the CASET strobe of each frame
// ---------------------------------------------------------------------------
module tft_cmd_sequencer
    import tft_pkg::*;
#(
    parameter int H_RES      = 240,
    parameter int V_RES      = 320,
    parameter int DELAY_UNIT = 10000,
    parameter int ROM_AW     = 6
)(
    input  logic        spiClk,
    input  logic        reset,
    input  logic        spi_idle,
    output logic [8:0]  spi_data,
    output logic        spi_dataAvailable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        init_done,
    output logic        frame_start
);

    localparam int                DCW      = 8 + $clog2(DELAY_UNIT + 1);
    localparam logic [16:0]       PIX_LAST = 17'(H_RES * V_RES - 1);
    localparam logic [15:0]       COL_END  = 16'(H_RES - 1);
    localparam logic [15:0]       ROW_END  = 16'(V_RES - 1);
    localparam logic [ROM_AW-1:0] ROM_LAST = {ROM_AW{1'b1}};
    localparam logic [3:0]        WIN_LAST = 4'(WIN_WORDS - 1);

    state_t            r_state,    w_state;
    src_t              r_src,      w_src;
    logic [ROM_AW-1:0] r_romIdx,   w_romIdx;
    logic [DCW-1:0]    r_delayCnt, w_delayCnt;
    logic [3:0]        r_winIdx,   w_winIdx;
    logic [16:0]       r_pixCnt,   w_pixCnt;
    logic [7:0]        r_pixLo,    w_pixLo;
    logic [8:0]        r_spiData,  w_spiData;
    logic              r_initDone, w_initDone;

    logic [9:0]        w_romWord;
    logic [1:0]        w_kind;
    logic [7:0]        w_payload;
    logic [DCW-1:0]    w_delayTotal;
    logic              w_issue;

    tft_init_rom #(
        .ROM_AW (ROM_AW)
    ) u_rom (
        .i_addr (r_romIdx),
        .o_word (w_romWord)
    );

    assign w_kind       = w_romWord[9:8];
    assign w_payload    = w_romWord[7:0];
    assign w_delayTotal = DCW'(w_payload) * DCW'(DELAY_UNIT);

    // The load strobe only fires while the serializer reports idle, so a
    // byte still in flight after a reset is allowed to finish first.
    assign w_issue           = (r_state == ST_ISSUE) && spi_idle;
    assign spi_dataAvailable = w_issue;
    assign spi_data          = r_spiData;
    assign init_done         = r_initDone;
    assign frame_start       = w_issue && (r_src == SRC_WIN) && (r_winIdx == 4'd0);
    assign pix_ready         = (r_state == ST_PIX_HI) && pix_valid && spi_idle;

    // State register and all datapath registers.
    always_ff @(posedge spiClk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_src      <= SRC_INIT;
            r_romIdx   <= '0;
            r_delayCnt <= '0;
            r_winIdx   <= '0;
            r_pixCnt   <= '0;
            r_pixLo    <= '0;
            r_spiData  <= '0;
            r_initDone <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_src      <= w_src;
            r_romIdx   <= w_romIdx;
            r_delayCnt <= w_delayCnt;
            r_winIdx   <= w_winIdx;
            r_pixCnt   <= w_pixCnt;
            r_pixLo    <= w_pixLo;
            r_spiData  <= w_spiData;
            r_initDone <= w_initDone;
        end
    end

    // Next-state logic. Every byte, whatever its origin, is loaded into
    // r_spiData by a one-cycle preparation state (FETCH, WIN, PIX_HI,
    // PIX_LO) and then goes through the shared ISSUE/ACK/WAIT handshake;
    // r_src tells WAIT where to continue afterwards.
    always_comb begin
        w_state    = r_state;
        w_src      = r_src;
        w_romIdx   = r_romIdx;
        w_delayCnt = r_delayCnt;
        w_winIdx   = r_winIdx;
        w_pixCnt   = r_pixCnt;
        w_pixLo    = r_pixLo;
        w_spiData  = r_spiData;
        w_initDone = r_initDone;

        case (r_state)
            ST_FETCH: begin
                // The last ROM address is always treated as END, so a script
                // without a terminator saturates there instead of wrapping.
                if ((w_kind == KIND_END) || (r_romIdx == ROM_LAST)) begin
                    w_initDone = 1'b1;
                    w_winIdx   = 4'd0;
                    w_state    = ST_WIN;
                end else if (w_kind == KIND_DELAY) begin
                    w_romIdx = r_romIdx + ROM_AW'(1);
                    // The FETCH of this entry and the FETCH of the next one
                    // already account for two cycles of the requested wait,
                    // so the counter only covers the remainder.
                    if (w_delayTotal < DCW'(2)) begin
                        w_state = ST_FETCH;
                    end else begin
                        w_delayCnt = w_delayTotal - DCW'(2);
                        w_state    = ST_DELAY;
                    end
                end else begin
                    w_spiData = {(w_kind == KIND_DATA), w_payload};
                    w_romIdx  = r_romIdx + ROM_AW'(1);
                    w_src     = SRC_INIT;
                    w_state   = ST_ISSUE;
                end
            end

            ST_DELAY: begin
                if (r_delayCnt == '0) begin
                    w_state = ST_FETCH;
                end else begin
                    w_delayCnt = r_delayCnt - DCW'(1);
                end
            end

            ST_WIN: begin
                w_spiData = winWord(r_winIdx, COL_END, ROW_END);
                w_src     = SRC_WIN;
                w_state   = ST_ISSUE;
            end

            ST_PIX_HI: begin
                // Only the low byte needs keeping; the high byte goes
                // straight into the output register.
                if (pix_valid && spi_idle) begin
                    w_pixLo   = pix_data[7:0];
                    w_spiData = {1'b1, pix_data[15:8]};
                    w_src     = SRC_PIX_HI;
                    w_state   = ST_ISSUE;
                end
            end

            ST_PIX_LO: begin
                w_spiData = {1'b1, r_pixLo};
                w_src     = SRC_PIX_LO;
                w_state   = ST_ISSUE;
            end

            ST_ISSUE: begin
                if (spi_idle) begin
                    w_state = ST_ACK;
                end
            end

            // The serializer drops idle during this cycle, so it is not
            // looked at here.
            ST_ACK: begin
                w_state = ST_WAIT;
            end

            ST_WAIT: begin
                if (spi_idle) begin
                    case (r_src)
                        SRC_INIT: begin
                            w_state = ST_FETCH;
                        end
                        SRC_WIN: begin
                            if (r_winIdx == WIN_LAST) begin
                                w_winIdx = 4'd0;
                                w_state  = ST_PIX_HI;
                            end else begin
                                w_winIdx = r_winIdx + 4'd1;
                                w_state  = ST_WIN;
                            end
                        end
                        SRC_PIX_HI: begin
                            w_state = ST_PIX_LO;
                        end
                        default: begin
                            if (r_pixCnt == PIX_LAST) begin
                                w_pixCnt = '0;
                                w_winIdx = 4'd0;
                                w_state  = ST_WIN;
                            end else begin
                                w_pixCnt = r_pixCnt + 17'd1;
                                w_state  = ST_PIX_HI;
                            end
                        end
                    endcase
                end
            end

            default: begin
                w_state = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_tft_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tft_cmd_sequencer
//   Small panel (4x2) and short delay unit. A behavioural serializer drops
//   idle the cycle after each load strobe and raises it 16 cycles later.
//   Expected words are queued when the stimulus side knows they must come
//   (script at reset, window at each frame wrap, byte pairs on pixel
//   acceptance); an independent monitor pops and compares on every strobe.
// ---------------------------------------------------------------------------
module tb_tft_cmd_sequencer;

   localparam int H_RES       = 4;
   localparam int V_RES       = 2;
   localparam int DELAY_UNIT  = 4;
   localparam int ROM_AW      = 6;
   localparam int NPIX        = H_RES * V_RES;
   localparam int SER_BUSY    = 16;
   localparam int SCRIPT_LEN  = 11;
   localparam int WAIT_BUDGET = 4000;

   typedef struct {
      logic [8:0] word;
      logic       fs;
      logic       initDone;
      int         gap;
   } exp_t;

   logic        spiClk;
   logic        reset;
   logic        spi_idle;
   logic [8:0]  spi_data;
   logic        spi_dataAvailable;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        init_done;
   logic        frame_start;

   int          total = 0;
   int          bad = 0;
   exp_t        expQ[$];
   exp_t        monE;
   logic [15:0] dirPix[$];
   int          cycle = 0;
   int          busy = 0;
   int          pixModelCnt = 0;
   bit          pixEnable = 0;
   int          strobeCount = 0;
   int          readyCount = 0;
   int          frameCount = 0;
   int          riseCycle = 0;
   logic        prevStrobe = 1'b0;
   logic        prevIdle = 1'b1;
   logic        haveLast = 1'b0;
   logic [8:0]  lastWord = 9'h000;

   // Panel init script as the designer wrote it: kind 0 CMD, 1 DATA,
   // 2 DELAY, 3 END.
   int scrKind[SCRIPT_LEN] = '{0, 2, 0, 2, 0, 1, 0, 1, 0, 2, 3};
   int scrVal [SCRIPT_LEN] = '{'h01, 5, 'h11, 12, 'h3A, 'h55, 'h36, 'h48, 'h29, 1, 0};

   tft_cmd_sequencer #(
      .H_RES      (H_RES),
      .V_RES      (V_RES),
      .DELAY_UNIT (DELAY_UNIT),
      .ROM_AW     (ROM_AW)
   ) dut (
      .spiClk            (spiClk),
      .reset             (reset),
      .spi_idle          (spi_idle),
      .spi_data          (spi_data),
      .spi_dataAvailable (spi_dataAvailable),
      .pix_data          (pix_data),
      .pix_valid         (pix_valid),
      .pix_ready         (pix_ready),
      .init_done         (init_done),
      .frame_start       (frame_start)
   );

   // Free-running clock
   initial begin
      spiClk = 1'b0;
      forever #5 spiClk = ~spiClk;
   end

   // Cycle counter used for timing gaps
   always @(posedge spiClk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pushExp(input logic [8:0] w, input logic fs, input logic idn, input int gap);
      exp_t e;
      e.word     = w;
      e.fs       = fs;
      e.initDone = idn;
      e.gap      = gap;
      expQ.push_back(e);
   endtask

   // Reference for the init script: each byte arrives 2 cycles after the
   // serializer becomes idle, plus any delays queued in between.
   task automatic pushInit();
      int pending;
      bit first;
      pending = 0;
      first   = 1'b1;
      for (int i = 0; i < SCRIPT_LEN; i++) begin
         if (scrKind[i] == 3) break;
         if (scrKind[i] == 2) begin
            pending += scrVal[i] * DELAY_UNIT;
         end else begin
            pushExp({(scrKind[i] == 1), 8'(scrVal[i])}, 1'b0, 1'b0, first ? -1 : 2 + pending);
            pending = 0;
            first   = 1'b0;
         end
      end
   endtask

   // Reference for the window setup; the CASET gap is only fixed when the
   // window follows a frame.
   task automatic pushWindow(input int firstGap);
      int         colEnd;
      int         rowEnd;
      logic [8:0] w[11];
      colEnd = H_RES - 1;
      rowEnd = V_RES - 1;
      w = '{ {1'b0, 8'h2A}, 9'h100, 9'h100, {1'b1, 8'(colEnd >> 8)}, {1'b1, 8'(colEnd)},
             {1'b0, 8'h2B}, 9'h100, 9'h100, {1'b1, 8'(rowEnd >> 8)}, {1'b1, 8'(rowEnd)},
             {1'b0, 8'h2C} };
      for (int i = 0; i < 11; i++) begin
         pushExp(w[i], (i == 0), 1'b1, (i == 0) ? firstGap : 2);
      end
   endtask

   // Run for a number of cycles
   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(negedge spiClk);
   endtask

   task automatic waitFrames(input int target, input string name);
      int n;
      n = 0;
      while (frameCount < target && n < WAIT_BUDGET) begin
         @(negedge spiClk);
         n++;
      end
      checkOutput(name, 32'(frameCount >= target), 32'd1);
   endtask

   // Serializer model and pixel source. Samples at the falling edge,
   // drives just after the rising edge.
   initial begin
      forever begin
         @(negedge spiClk);
         if (!reset && pix_ready) begin
            readyCount++;
            checkOutput("readyNeedsValid", 32'(pix_valid), 32'd1);
            checkOutput("readyBetweenPixels", 32'(expQ.size()), 32'd0);
            pushExp({1'b1, pix_data[15:8]}, 1'b0, 1'b1, -1);
            pushExp({1'b1, pix_data[7:0]}, 1'b0, 1'b1, 2);
            if (dirPix.size() != 0) void'(dirPix.pop_front());
            pixModelCnt++;
            if (pixModelCnt == NPIX) begin
               pixModelCnt = 0;
               pushWindow(2);
            end
         end
         if (spi_dataAvailable) busy = SER_BUSY;
         @(posedge spiClk);
         #2;
         if (busy > 0) begin
            spi_idle = 1'b0;
            busy--;
         end else begin
            spi_idle = 1'b1;
         end
         if (!pixEnable) begin
            pix_valid = 1'b0;
         end else if (dirPix.size() != 0) begin
            pix_valid = 1'b1;
            pix_data  = dirPix[0];
         end else begin
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_data  = 16'($urandom);
         end
      end
   end

   // Monitor: compares every load strobe against the scoreboard
   always @(negedge spiClk) begin
      if (reset) begin
         haveLast   = 1'b0;
         prevStrobe = 1'b0;
         prevIdle   = spi_idle;
      end else begin
         if (spi_idle && !prevIdle) begin
            riseCycle = cycle;
            if (haveLast) checkOutput("dataHeldThroughWait", 32'(spi_data), 32'(lastWord));
         end
         if (spi_dataAvailable) begin
            strobeCount++;
            checkOutput("strobeSpacing", 32'(prevStrobe), 32'd0);
            checkOutput("strobeNeedsIdle", 32'(spi_idle), 32'd1);
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpectedStrobe: got %03h expected none", spi_data);
            end else begin
               monE = expQ.pop_front();
               checkOutput("word", 32'(spi_data), 32'(monE.word));
               checkOutput("frameStart", 32'(frame_start), 32'(monE.fs));
               checkOutput("initDone", 32'(init_done), 32'(monE.initDone));
               if (monE.gap >= 0) checkOutput("gapAfterIdle", 32'(cycle - riseCycle), 32'(monE.gap));
            end
            lastWord = spi_data;
            haveLast = 1'b1;
         end else if (frame_start) begin
            checkOutput("frameStartWithoutStrobe", 32'(frame_start), 32'd0);
         end
         if (frame_start) frameCount++;
         prevStrobe = spi_dataAvailable;
         prevIdle   = spi_idle;
      end
   end

   initial begin
      int n;
      int s0;
      int r0;
      int f0;
      reset     = 1'b1;
      spi_idle  = 1'b1;
      pix_valid = 1'b0;
      pix_data  = 16'h0000;
      repeat (3) @(posedge spiClk);
      @(negedge spiClk);
      checkOutput("rstSpiData", 32'(spi_data), 32'd0);
      checkOutput("rstStrobe", 32'(spi_dataAvailable), 32'd0);
      checkOutput("rstPixReady", 32'(pix_ready), 32'd0);
      checkOutput("rstInitDone", 32'(init_done), 32'd0);
      checkOutput("rstFrameStart", 32'(frame_start), 32'd0);

      pushInit();
      pushWindow(-1);
      dirPix.push_back(16'hF800);
      dirPix.push_back(16'h07E0);
      pixEnable = 1'b1;
      @(posedge spiClk);
      #2 reset = 1'b0;

      waitFrames(1, "firstFrameStart");
      checkOutput("initDoneHigh", 32'(init_done), 32'd1);
      waitFrames(3, "thirdFrameStart");
      checkOutput("pixelsInTwoFrames", 32'(readyCount), 32'(2 * NPIX));

      // Pixel source goes quiet while the sequencer sits in PIX_HI
      pixEnable = 1'b0;
      n = 0;
      while ((expQ.size() != 0 || !spi_idle) && n < WAIT_BUDGET) begin
         @(negedge spiClk);
         n++;
      end
      checkOutput("drainedBeforeHold", 32'(expQ.size()), 32'd0);
      s0 = strobeCount;
      r0 = readyCount;
      applyStimulus(50);
      checkOutput("holdNoStrobe", 32'(strobeCount - s0), 32'd0);
      checkOutput("holdNoReady", 32'(readyCount - r0), 32'd0);
      pixEnable = 1'b1;
      n = 0;
      while (readyCount == r0 && n < WAIT_BUDGET) begin
         @(negedge spiClk);
         n++;
      end
      checkOutput("resumeOnValid", 32'(readyCount > r0), 32'd1);

      // Reset while the serializer is still shifting a byte out
      s0 = strobeCount;
      n  = 0;
      while (strobeCount == s0 && n < WAIT_BUDGET) begin
         @(negedge spiClk);
         n++;
      end
      applyStimulus(3);
      @(posedge spiClk);
      #3 reset = 1'b1;
      #1;
      checkOutput("midRstStrobe", 32'(spi_dataAvailable), 32'd0);
      checkOutput("midRstSpiData", 32'(spi_data), 32'd0);
      checkOutput("midRstInitDone", 32'(init_done), 32'd0);
      checkOutput("midRstPixReady", 32'(pix_ready), 32'd0);
      checkOutput("midRstFrameStart", 32'(frame_start), 32'd0);
      expQ.delete();
      dirPix.delete();
      pixModelCnt = 0;
      pushInit();
      pushWindow(-1);
      f0 = frameCount;
      repeat (2) @(posedge spiClk);
      #2 reset = 1'b0;
      s0 = strobeCount;
      n  = 0;
      while (strobeCount == s0 && n < WAIT_BUDGET) begin
         @(negedge spiClk);
         n++;
      end
      checkOutput("postResetFirstWord", 32'(lastWord), 32'h001);
      waitFrames(f0 + 2, "framesAfterReset");

      pixEnable = 1'b0;
      applyStimulus(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
